cache_l2a_responder: RTL and testbench

- Responder side of the L1a↔L2a request protocol: the L2a cache controller that serves L1a read (allocate), write (inclusion write-through) and write-back requests.
- Direct-mapped L2a store with valid/dirty/tag state per set.
- On miss, fetches from L3a and evicts dirty victims to L3a using the same request/acknowledge protocol shape toward L3a.
- Sits between the L1a cache FSM and the L3a controller for processor 0.

---
 rtl/cache_l2a_responder_pkg.sv | 9 +
 rtl/l2a_tag_data_array.sv | 56 +++++
 rtl/cache_l2a_responder.sv | 207 ++++++++++++++++++++
 tb/tb_cache_l2a_responder.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_l2a_responder_pkg.sv
// Shared configuration for the L2a responder: set geometry, FSM states and request kinds.
package cache_l2a_responder_pkg;
  localparam int L2_NUM_SETS    = 16;
  localparam int L2_INDEX_WIDTH = $clog2(L2_NUM_SETS);
  localparam int L2_TAG_WIDTH   = 30 - 4 - L2_INDEX_WIDTH;

  typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, FILL, RESPOND, DONE} l2_state_t;
  typedef enum logic [1:0] {REQ_READ, REQ_WRITE, REQ_WB} req_kind_t;
endpackage

// File: rtl/l2a_tag_data_array.sv
// Direct-mapped tag/valid/dirty/data store: combinational read port, synchronous
// write port with a per-word enable mask. Only valid/dirty are cleared by reset.
module l2a_tag_data_array #(
  parameter int NUM_SETS = 16,
  parameter int IDX_W    = 4,
  parameter int TAG_W    = 22,
  parameter int BLOCK_W  = 128,
  parameter int WORD_W   = 32,
  localparam int WORDS   = BLOCK_W / WORD_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IDX_W-1:0]   rd_index,
  output logic [TAG_W-1:0]   rd_tag,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [BLOCK_W-1:0] rd_block,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_index,
  input  logic [WORDS-1:0]   wr_word_mask,
  input  logic [BLOCK_W-1:0] wr_block,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic               wr_valid,
  input  logic               wr_dirty
);
  logic [TAG_W-1:0]    tag_mem [NUM_SETS];
  logic [NUM_SETS-1:0] valid_reg;
  logic [NUM_SETS-1:0] dirty_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg <= '0;
      dirty_reg <= '0;
    end else if (wr_en) begin
      valid_reg[wr_index] <= wr_valid;
      dirty_reg[wr_index] <= wr_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) tag_mem[wr_index] <= wr_tag;
  end

  // One storage array per word lane so the mask maps onto independent write enables.
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
    logic [WORD_W-1:0] word_mem [NUM_SETS];
    always_ff @(posedge clk) begin
      if (wr_en && wr_word_mask[gi]) word_mem[wr_index] <= wr_block[gi*WORD_W +: WORD_W];
    end
    assign rd_block[gi*WORD_W +: WORD_W] = word_mem[rd_index];
  end

  assign rd_tag   = tag_mem[rd_index];
  assign rd_valid = valid_reg[rd_index];
  assign rd_dirty = dirty_reg[rd_index];
endmodule

// File: rtl/cache_l2a_responder.sv
// L2a controller serving L1a read/write/write-back requests, with miss fill and
// dirty-victim eviction toward L3a over the same request/acknowledge handshake.
module cache_l2a_responder #(
  parameter int         ADDRESS_WIDTH          = 32,
  parameter int         DATA_WIDTH             = 32,
  parameter int         MAIN_MEMORY_DATA_WIDTH = 128,
  parameter int         L2_NUM_SETS            = 16,
  parameter logic [1:0] PROC_ID                = 2'b00
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              read_from_L2a_request,
  input  logic                              write_to_L2a_request,
  input  logic                              write_back_to_L2a_request,
  input  logic [ADDRESS_WIDTH-1:0]          cache_L2a_memory_address,
  input  logic [DATA_WIDTH-1:0]             cache_1a_write_data_to_L2a,
  input  logic [MAIN_MEMORY_DATA_WIDTH-1:0] write_back_to_L2a_data,
  output logic [MAIN_MEMORY_DATA_WIDTH-1:0] write_data_to_L1a_from_L2a,
  output logic                              L2a_ready,
  output logic                              write_to_L2a_verified,
  output logic                              write_back_to_L2a_verified,
  output logic                              read_from_L3a_request,
  output logic                              write_back_to_L3a_request,
  output logic [ADDRESS_WIDTH-1:0]          cache_L3a_memory_address,
  output logic [MAIN_MEMORY_DATA_WIDTH-1:0] write_back_to_L3a_data,
  input  logic                              L3a_ready,
  input  logic [MAIN_MEMORY_DATA_WIDTH-1:0] write_data_to_L2a_from_L3a,
  input  logic                              write_back_to_L3a_verified,
  output logic                              L2a_cache_hit,
  output logic                              L2a_cache_miss
);
  localparam int IDX_W = $clog2(L2_NUM_SETS);
  localparam int TAG_W = ADDRESS_WIDTH - 2 - 4 - IDX_W;
  localparam int WORDS = MAIN_MEMORY_DATA_WIDTH / DATA_WIDTH;
  localparam int OFF_W = $clog2(WORDS);

  import cache_l2a_responder_pkg::*;

  l2_state_t                   state;
  req_kind_t                   kind_reg;
  logic [TAG_W-1:0]            tag_reg;
  logic [IDX_W-1:0]            idx_reg;
  logic [OFF_W-1:0]            off_reg;
  logic [DATA_WIDTH-1:0]       word_reg;
  logic [MAIN_MEMORY_DATA_WIDTH-1:0] block_reg;

  logic [TAG_W-1:0]            rd_tag;
  logic                        rd_valid, rd_dirty;
  logic [MAIN_MEMORY_DATA_WIDTH-1:0] rd_block;
  logic                        arr_we;
  logic [WORDS-1:0]            arr_mask;
  logic [MAIN_MEMORY_DATA_WIDTH-1:0] arr_block;
  logic [TAG_W-1:0]            arr_tag;
  logic                        arr_dirty;

  logic hit, any_req, own_req, unused_bits;
  logic is_read, is_write, is_wb;

  assign unused_bits = ^cache_L2a_memory_address[1:0];
  assign any_req  = read_from_L2a_request | write_to_L2a_request | write_back_to_L2a_request;
  assign own_req  = any_req && (cache_L2a_memory_address[ADDRESS_WIDTH-1 -: 2] == PROC_ID);
  assign hit      = rd_valid && (rd_tag == tag_reg);
  assign is_read  = (kind_reg == REQ_READ);
  assign is_write = (kind_reg == REQ_WRITE);
  assign is_wb    = (kind_reg == REQ_WB);
  assign L2a_cache_hit  = (state == LOOKUP) && hit;
  assign L2a_cache_miss = (state == LOOKUP) && !hit;

  l2a_tag_data_array #(
    .NUM_SETS (L2_NUM_SETS),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W),
    .BLOCK_W  (MAIN_MEMORY_DATA_WIDTH),
    .WORD_W   (DATA_WIDTH)
  ) u_array (
    .clk          (clk),
    .reset        (reset),
    .rd_index     (idx_reg),
    .rd_tag       (rd_tag),
    .rd_valid     (rd_valid),
    .rd_dirty     (rd_dirty),
    .rd_block     (rd_block),
    .wr_en        (arr_we),
    .wr_index     (idx_reg),
    .wr_word_mask (arr_mask),
    .wr_block     (arr_block),
    .wr_tag       (arr_tag),
    .wr_valid     (1'b1),
    .wr_dirty     (arr_dirty)
  );

  // Every array update targets the latched set; the evict case only rewrites metadata.
  always_comb begin
    arr_we    = 1'b0;
    arr_mask  = '0;
    arr_block = block_reg;
    arr_tag   = tag_reg;
    arr_dirty = 1'b1;
    case (state)
      EVICT: if (write_back_to_L3a_verified) begin
        arr_we    = 1'b1;
        arr_tag   = rd_tag;
        arr_dirty = 1'b0;
      end
      FILL: if (L3a_ready) begin
        arr_we    = 1'b1;
        arr_mask  = '1;
        arr_block = write_data_to_L2a_from_L3a;
        arr_dirty = 1'b0;
      end
      RESPOND: begin
        if (is_write) begin
          arr_we           = 1'b1;
          arr_mask[off_reg] = 1'b1;
          arr_block        = {WORDS{word_reg}};
        end else if (is_wb) begin
          arr_we   = 1'b1;
          arr_mask = '1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                      <= IDLE;
      kind_reg                   <= REQ_READ;
      tag_reg                    <= '0;
      idx_reg                    <= '0;
      off_reg                    <= '0;
      word_reg                   <= '0;
      block_reg                  <= '0;
      write_data_to_L1a_from_L2a <= '0;
      L2a_ready                  <= 1'b0;
      write_to_L2a_verified      <= 1'b0;
      write_back_to_L2a_verified <= 1'b0;
      read_from_L3a_request      <= 1'b0;
      write_back_to_L3a_request  <= 1'b0;
      cache_L3a_memory_address   <= '0;
      write_back_to_L3a_data     <= '0;
    end else begin
      L2a_ready                  <= 1'b0;
      write_to_L2a_verified      <= 1'b0;
      write_back_to_L2a_verified <= 1'b0;
      write_data_to_L1a_from_L2a <= '0;
      case (state)
        IDLE: if (own_req) begin
          tag_reg   <= cache_L2a_memory_address[ADDRESS_WIDTH-3 -: TAG_W];
          idx_reg   <= cache_L2a_memory_address[4 +: IDX_W];
          off_reg   <= cache_L2a_memory_address[2 +: OFF_W];
          word_reg  <= cache_1a_write_data_to_L2a;
          block_reg <= write_back_to_L2a_data;
          kind_reg  <= write_back_to_L2a_request ? REQ_WB :
                       write_to_L2a_request      ? REQ_WRITE : REQ_READ;
          state     <= LOOKUP;
        end
        LOOKUP: begin
          if (hit) begin
            state                      <= RESPOND;
            L2a_ready                  <= is_read;
            write_to_L2a_verified      <= is_write;
            write_back_to_L2a_verified <= is_wb;
            if (is_read) write_data_to_L1a_from_L2a <= rd_block;
          end else if (rd_valid && rd_dirty) begin
            state                     <= EVICT;
            write_back_to_L3a_request <= 1'b1;
            cache_L3a_memory_address  <= {PROC_ID, rd_tag, idx_reg, 4'b0};
            write_back_to_L3a_data    <= rd_block;
          end else if (is_wb) begin
            state                      <= RESPOND;
            write_back_to_L2a_verified <= 1'b1;
          end else begin
            state                    <= FILL;
            read_from_L3a_request    <= 1'b1;
            cache_L3a_memory_address <= {PROC_ID, tag_reg, idx_reg, 4'b0};
          end
        end
        EVICT: if (write_back_to_L3a_verified) begin
          write_back_to_L3a_request <= 1'b0;
          write_back_to_L3a_data    <= '0;
          if (is_wb) begin
            state                      <= RESPOND;
            write_back_to_L2a_verified <= 1'b1;
            cache_L3a_memory_address   <= '0;
          end else begin
            state                    <= FILL;
            read_from_L3a_request    <= 1'b1;
            cache_L3a_memory_address <= {PROC_ID, tag_reg, idx_reg, 4'b0};
          end
        end
        FILL: if (L3a_ready) begin
          read_from_L3a_request    <= 1'b0;
          cache_L3a_memory_address <= '0;
          state                    <= RESPOND;
          L2a_ready                <= is_read;
          write_to_L2a_verified    <= is_write;
          if (is_read) write_data_to_L1a_from_L2a <= write_data_to_L2a_from_L3a;
        end
        RESPOND: state <= DONE;
        // Wait for the L1a side to drop its request so a held request is not served twice.
        DONE: if (!any_req) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_l2a_responder.sv
// Directed scoreboard bench: expected L1a acknowledges and L3a transactions are queued
// at stimulus time and popped when the DUT produces them.
module tb_cache_l2a_responder;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         read_req, write_req, wb_req;
  logic [31:0]  address, write_word;
  logic [127:0] wb_block;
  logic [127:0] l1_data;
  logic         l2_ready, write_verified, wb_verified;
  logic         l3_read_req, l3_wb_req;
  logic [31:0]  l3_addr;
  logic [127:0] l3_wb_data;
  logic         l3_ready, l3_wb_verified;
  logic [127:0] l3_data;
  logic         cache_hit, cache_miss;

  always #5 clk = ~clk;

  cache_l2a_responder dut (
    .clk                        (clk),
    .reset                      (rst_n),
    .read_from_L2a_request      (read_req),
    .write_to_L2a_request       (write_req),
    .write_back_to_L2a_request  (wb_req),
    .cache_L2a_memory_address   (address),
    .cache_1a_write_data_to_L2a (write_word),
    .write_back_to_L2a_data     (wb_block),
    .write_data_to_L1a_from_L2a (l1_data),
    .L2a_ready                  (l2_ready),
    .write_to_L2a_verified      (write_verified),
    .write_back_to_L2a_verified (wb_verified),
    .read_from_L3a_request      (l3_read_req),
    .write_back_to_L3a_request  (l3_wb_req),
    .cache_L3a_memory_address   (l3_addr),
    .write_back_to_L3a_data     (l3_wb_data),
    .L3a_ready                  (l3_ready),
    .write_data_to_L2a_from_L3a (l3_data),
    .write_back_to_L3a_verified (l3_wb_verified),
    .L2a_cache_hit              (cache_hit),
    .L2a_cache_miss             (cache_miss)
  );

  typedef struct { logic [2:0] ack; logic [127:0] data; } exp_t;      // ack = {ready, write, wb}
  typedef struct { logic wb; logic [31:0] addr; logic [127:0] data; } l3_exp_t;

  exp_t    exp_q[$];
  l3_exp_t l3_q[$];
  logic [127:0] l3_mem [logic [31:0]];

  int errors = 0, checks = 0;
  int cyc = 0, ack_count = 0, ack_cyc = 0, hit_count = 0, miss_count = 0, l3_busy = 0;

  localparam logic [2:0] K_READ = 3'b100, K_WRITE = 3'b010, K_WB = 3'b001;
  localparam logic [127:0] BLK_A  = {4{32'hAAAA_AAAA}};
  localparam logic [127:0] BLK_M1 = {32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h1234_5678, 32'hAAAA_AAAA};
  localparam logic [127:0] BLK_W  = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
  localparam logic [127:0] BLK_W2 = {32'hDEAD_BEEF, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] l3_default(input logic [31:0] a);
    return (a == 32'h40) ? BLK_A : {4{a ^ 32'h5A5A_0000}};
  endfunction

  // L1a-side monitor: pops the scoreboard on every acknowledge.
  initial forever begin
    logic [2:0] ack;
    exp_t e;
    @(negedge clk);
    if (rst_n === 1'b1) begin
      ack = {l2_ready, write_verified, wb_verified};
      hit_count  += int'(cache_hit);
      miss_count += int'(cache_miss);
      if (l3_read_req || l3_wb_req) l3_busy++;
      if (ack != 3'b000) begin
        ack_count++;
        ack_cyc = cyc;
        if (exp_q.size() == 0) check("unexpected_ack", ack, 3'b000);
        else begin
          e = exp_q.pop_front();
          check("ack_kind", ack, e.ack);
          if (e.ack == K_READ) check("read_data", l1_data, e.data);
        end
      end
      if (ack != K_READ) check("l1_data_zero", l1_data, '0);
    end
  end

  // L3a model: fetch answered 2 cycles after request appears, write-back after 1.
  initial begin
    int fcnt, wcnt;
    l3_exp_t e;
    fcnt = 0; wcnt = 0;
    l3_ready = 1'b0; l3_wb_verified = 1'b0; l3_data = '0;
    forever begin
      @(negedge clk);
      l3_ready = 1'b0;
      l3_wb_verified = 1'b0;
      if (rst_n !== 1'b1) begin
        fcnt = 0; wcnt = 0;
      end else begin
        if (l3_read_req) begin
          fcnt++;
          if (fcnt == 3) begin
            fcnt = 0;
            l3_data  = l3_mem.exists(l3_addr) ? l3_mem[l3_addr] : l3_default(l3_addr);
            l3_ready = 1'b1;
            if (l3_q.size() == 0) check("unexpected_l3_fetch", {96'b0, l3_addr}, '0);
            else begin
              e = l3_q.pop_front();
              check("l3_kind_fetch", {127'b0, e.wb}, 128'd0);
              check("l3_fetch_addr", {96'b0, l3_addr}, {96'b0, e.addr});
            end
          end
        end else fcnt = 0;
        if (l3_wb_req) begin
          wcnt++;
          if (wcnt == 2) begin
            wcnt = 0;
            l3_mem[l3_addr] = l3_wb_data;
            l3_wb_verified  = 1'b1;
            if (l3_q.size() == 0) check("unexpected_l3_wb", {96'b0, l3_addr}, '0);
            else begin
              e = l3_q.pop_front();
              check("l3_kind_wb", {127'b0, e.wb}, 128'd1);
              check("l3_wb_addr", {96'b0, l3_addr}, {96'b0, e.addr});
              check("l3_wb_data", l3_wb_data, e.data);
            end
          end
        end else wcnt = 0;
      end
    end
  end

  task automatic wait_ack(input int base, output bit got);
    got = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk); #2;
      if (ack_count != base) got = 1'b1;
    end
  endtask

  task automatic do_req(input logic [2:0] kind, input logic [31:0] a, input logic [31:0] w,
                        input logic [127:0] b, input int hold, output int lat);
    int base, start;
    bit got;
    base = ack_count;
    @(negedge clk); #2;
    address = a; write_word = w; wb_block = b;
    {read_req, write_req, wb_req} = kind;
    start = cyc;
    wait_ack(base, got);
    check("ack_seen", {127'b0, got}, 128'd1);
    lat = ack_cyc - start;
    repeat (hold) @(negedge clk);
    #2 {read_req, write_req, wb_req} = 3'b000;
    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check(tag, {l2_ready, write_verified, wb_verified, l3_read_req, l3_wb_req, cache_hit, cache_miss}, '0);
    check({tag, "_data"}, l1_data | l3_wb_data | {96'b0, l3_addr}, '0);
  endtask

  initial begin
    int lat, h0, m0, a0, b0;
    bit got;
    rst_n = 1'b0;
    {read_req, write_req, wb_req} = 3'b000;
    address = '0; write_word = '0; wb_block = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_outputs");
    rst_n = 1'b1;

    // Cold read miss: fetch 0x40 from L3a
    h0 = hit_count; m0 = miss_count;
    l3_q.push_back('{wb: 1'b0, addr: 32'h40, data: '0});
    exp_q.push_back('{ack: K_READ, data: BLK_A});
    do_req(K_READ, 32'h40, 0, 0, 0, lat);
    check("miss_pulse", miss_count - m0, 1);
    check("miss_no_hit", hit_count - h0, 0);
    check("clean_miss_latency", lat, 5);
    $display("read 0x40 miss latency=%0d", lat);

    // Repeat read hits with 2-cycle latency
    h0 = hit_count;
    exp_q.push_back('{ack: K_READ, data: BLK_A});
    do_req(K_READ, 32'h40, 0, 0, 0, lat);
    check("hit_pulse", hit_count - h0, 1);
    check("hit_latency", lat, 2);
    $display("read 0x40 hit latency=%0d", lat);

    // Word write into offset 1, then read back
    exp_q.push_back('{ack: K_WRITE, data: '0});
    do_req(K_WRITE, 32'h44, 32'h1234_5678, 0, 0, lat);
    exp_q.push_back('{ack: K_READ, data: BLK_M1});
    do_req(K_READ, 32'h40, 0, 0, 0, lat);
    $display("write 0x44 then read 0x40 done");

    // Conflict miss on dirty index 4: evict 0x40 then fetch 0x140
    l3_q.push_back('{wb: 1'b1, addr: 32'h40, data: BLK_M1});
    l3_q.push_back('{wb: 1'b0, addr: 32'h140, data: '0});
    exp_q.push_back('{ack: K_READ, data: {4{32'h5A5A_0140}}});
    do_req(K_READ, 32'h140, 0, 0, 0, lat);
    $display("read 0x140 with dirty eviction done");

    // Bring 0x40 back: clean victim, no eviction, data is the written-back block
    l3_q.push_back('{wb: 1'b0, addr: 32'h40, data: '0});
    exp_q.push_back('{ack: K_READ, data: BLK_M1});
    do_req(K_READ, 32'h40, 0, 0, 0, lat);
    $display("refetch 0x40 done");

    // Simultaneous read + write-back: write-back wins, read waits for release
    a0 = ack_count;
    exp_q.push_back('{ack: K_WB, data: '0});
    @(negedge clk); #2;
    address = 32'h40; wb_block = BLK_W; {read_req, write_req, wb_req} = 3'b101;
    wait_ack(a0, got);
    check("wb_ack_seen", {127'b0, got}, 128'd1);
    repeat (4) @(negedge clk);
    check("wb_read_single_ack", ack_count - a0, 1);
    #2 {read_req, write_req, wb_req} = 3'b000;
    repeat (2) @(negedge clk);
    h0 = hit_count;
    exp_q.push_back('{ack: K_READ, data: BLK_W});
    do_req(K_READ, 32'h40, 0, 0, 0, lat);
    check("wb_then_read_hit", hit_count - h0, 1);
    $display("write-back + read priority done");

    // Request held 5 cycles after its acknowledge gets exactly one ack
    a0 = ack_count;
    exp_q.push_back('{ack: K_READ, data: BLK_W});
    do_req(K_READ, 32'h40, 0, 0, 5, lat);
    check("held_single_ack", ack_count - a0, 1);
    $display("held read done");

    // Foreign processor ID is ignored
    a0 = ack_count; b0 = l3_busy; h0 = hit_count; m0 = miss_count;
    @(negedge clk); #2;
    address = 32'h4000_0040; read_req = 1'b1;
    repeat (10) @(negedge clk);
    #2 read_req = 1'b0;
    repeat (2) @(negedge clk);
    check("proc1_no_ack", ack_count - a0, 0);
    check("proc1_no_l3", l3_busy - b0, 0);
    check("proc1_no_lookup", (hit_count - h0) + (miss_count - m0), 0);
    $display("proc1 request ignored");

    // Offset 3 targets the top word
    exp_q.push_back('{ack: K_WRITE, data: '0});
    do_req(K_WRITE, 32'h4C, 32'hDEAD_BEEF, 0, 0, lat);
    exp_q.push_back('{ack: K_READ, data: BLK_W2});
    do_req(K_READ, 32'h40, 0, 0, 0, lat);
    $display("offset 3 write done");

    // Highest index
    l3_q.push_back('{wb: 1'b0, addr: 32'hF0, data: '0});
    exp_q.push_back('{ack: K_READ, data: {4{32'h5A5A_00F0}}});
    do_req(K_READ, 32'hF0, 0, 0, 0, lat);
    $display("read 0xF0 done");

    // Reset in the middle of a fill
    got = 1'b0;
    @(negedge clk); #2;
    address = 32'h200; read_req = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk); #2;
      if (l3_read_req) got = 1'b1;
    end
    check("fill_started", {127'b0, got}, 128'd1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midfill_reset_outputs");
    read_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    h0 = hit_count; m0 = miss_count;
    l3_q.push_back('{wb: 1'b0, addr: 32'h40, data: '0});
    exp_q.push_back('{ack: K_READ, data: BLK_M1});
    do_req(K_READ, 32'h40, 0, 0, 0, lat);
    check("post_reset_miss", miss_count - m0, 1);
    check("post_reset_no_hit", hit_count - h0, 0);
    $display("reset mid-fill, 0x40 refetched");

    repeat (4) @(negedge clk);
    check("l3_drained", l3_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
